alu_arbiter: RTL

Two-requester round-robin arbiter wrapped around the single shared `alu` instance. Each cycle it grants at most one requester, drives that requester's operands, opcode and shift amount into the ALU, and captures the result and flags into that requester's response register. Each requester sees a valid/ready request channel and a valid/ready response channel, with at most one operation outstanding per requester.

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter around one shared combinational ALU; ALU_ARB_OPCHECK_EN flags opcodes 6..31.
// Latency: accept at edge k, response valid in cycle k+1; aggregate one operation per cycle.
// Backpressure: a full, unconsumed response slot blocks only its own requester.

module alu (
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  opcode,
  input  logic [4:0]  shamt,
  output logic [31:0] data_result,
  output logic        overflow,
  output logic        is_less_than,
  output logic        is_not_equal
);
  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    data_result = '0;
    overflow    = 1'b0;
    case (opcode)
      5'd0: begin
        data_result = sum;
        overflow    = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      5'd1: begin
        data_result = diff;
        overflow    = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      5'd2:    data_result = op_a & op_b;
      5'd3:    data_result = op_a | op_b;
      5'd4:    data_result = op_a << shamt;
      5'd5:    data_result = $signed(op_a) >>> shamt;
      default: data_result = '0;
    endcase
    // Compare flags come from the raw difference sign, not an overflow-corrected compare.
    is_less_than = diff[31];
    is_not_equal = |diff;
  end
endmodule

module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_opA,
  input  logic [31:0] req0_opB,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req0_shamt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [2:0]  rsp0_flags,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_opA,
  input  logic [31:0] req1_opB,
  input  logic [4:0]  req1_opcode,
  input  logic [4:0]  req1_shamt,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [2:0]  rsp1_flags,
  output logic        rsp1_err
);
  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
    logic        err;
  } rsp_t;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            last_q, last_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  rsp_t            rsp0_q, rsp0_d;
  rsp_t            rsp1_q, rsp1_d;
  rsp_t            alu_rsp;

  logic [31:0] alu_a, alu_b, alu_y;
  logic [4:0]  alu_op, alu_sh;
  logic        alu_ovf, alu_lt, alu_ne;

  alu u_alu (
    .op_a         (alu_a),
    .op_b         (alu_b),
    .opcode       (alu_op),
    .shamt        (alu_sh),
    .data_result  (alu_y),
    .overflow     (alu_ovf),
    .is_less_than (alu_lt),
    .is_not_equal (alu_ne)
  );

  always_comb begin
    elig[0] = req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig[1] = req1_valid && (!rsp1_valid_q || rsp1_ready);
    gnt     = '0;
    // last_q=1 means requester 1 won most recently, so requester 0 wins a tie.
    if (reset_n) begin
      if (elig[0] && (!elig[1] || last_q)) gnt[0] = 1'b1;
      else if (elig[1])                    gnt[1] = 1'b1;
    end
    last_d = last_q;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;

    alu_a  = gnt[1] ? req1_opA    : req0_opA;
    alu_b  = gnt[1] ? req1_opB    : req0_opB;
    alu_op = gnt[1] ? req1_opcode : req0_opcode;
    alu_sh = gnt[1] ? req1_shamt  : req0_shamt;

`ifdef ALU_ARB_OPCHECK_EN
    if (alu_op > 5'd5) begin
      alu_rsp = '{result: '0, flags: '0, err: 1'b1};
    end else begin
      alu_rsp = '{result: alu_y, flags: {alu_ovf, alu_lt, alu_ne}, err: 1'b0};
    end
`else
    alu_rsp = '{result: alu_y, flags: {alu_ovf, alu_lt, alu_ne}, err: 1'b0};
`endif

    rsp0_d       = gnt[0] ? alu_rsp : rsp0_q;
    rsp1_d       = gnt[1] ? alu_rsp : rsp1_q;
    rsp0_valid_d = gnt[0] ? 1'b1 : (rsp0_valid_q && !rsp0_ready ? 1'b1 : 1'b0);
    rsp1_valid_d = gnt[1] ? 1'b1 : (rsp1_valid_q && !rsp1_ready ? 1'b1 : 1'b0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_q       <= '0;
      rsp1_q       <= '0;
    end else begin
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
    end
  end

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_q.result;
  assign rsp0_flags  = rsp0_q.flags;
  assign rsp0_err    = rsp0_q.err;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_q.result;
  assign rsp1_flags  = rsp1_q.flags;
  assign rsp1_err    = rsp1_q.err;
endmodule
